// File: rtl/gpio_msg_dma.sv
// gpio_msg_dma: copies NUM_WORDS words from dmem into a message buffer and
// presents them to gpio_protocol through its data_ready/done handshake.
// The processor shares the single dmem port and normally wins it. After
// STARVE_LIMIT consecutive lost cycles, the DMA takes the port for one cycle.
module gpio_msg_dma #(
    parameter int                ADDR_W       = 12,
    parameter int                DATA_W       = 32,
    parameter int                NUM_WORDS    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 12'd1000,
    parameter int                STARVE_LIMIT = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          proc_mem_en,
    input  logic [ADDR_W-1:0]             proc_address,
    input  logic [DATA_W-1:0]             proc_data,
    input  logic                          proc_wren,
    output logic [ADDR_W-1:0]             dmem_address,
    output logic [DATA_W-1:0]             dmem_data,
    output logic                          dmem_wren,
    input  logic [DATA_W-1:0]             dmem_q,
    output logic                          proc_stall,
    output logic [NUM_WORDS*DATA_W-1:0]   message_out,
    output logic                          data_ready,
    input  logic                          done,
    output logic                          busy,
    output logic                          xfer_done,
    output logic                          start_overrun
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [SW-1:0]    LIMIT    = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, READ, ARM, DRAIN} state_t;

    state_t              state;
    state_t              state_next;
    logic [IDX_W-1:0]    index;
    logic [SW-1:0]       starve_cnt;
    logic [DATA_W-1:0]   word [NUM_WORDS];
    logic                dma_grant;
    logic                last;

    // Port arbitration: the processor wins unless the DMA has starved too long.
    always_comb begin
        dma_grant  = (state == READ) && (!proc_mem_en || starve_cnt == LIMIT);
        last       = (index == LAST_IDX);
        proc_stall = proc_mem_en && dma_grant;
        dmem_data  = proc_data;
        if (dma_grant) begin
            dmem_address = BASE_ADDR + ADDR_W'(index);
            dmem_wren    = 1'b0;
        end else begin
            dmem_address = proc_address;
            dmem_wren    = proc_wren;
        end
        busy      = (state != IDLE);
        // Completion is flagged while still in DRAIN, so a start in that same
        // cycle still sees a busy controller.
        xfer_done = (state == DRAIN) && !done;
    end

    // Next-state decode for the transfer/handshake sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)             state_next = READ;
            READ:    if (dma_grant && last) state_next = ARM;
            ARM:     if (done)              state_next = DRAIN;
            DRAIN:   if (!done)             state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // State register, registered data_ready and sticky overrun flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            data_ready    <= 1'b0;
            start_overrun <= 1'b0;
        end else begin
            state      <= state_next;
            data_ready <= (state_next == ARM);
            if (start && state != IDLE)
                start_overrun <= 1'b1;
        end
    end

    // Word index and starvation counter; the counter only runs while yielding.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index      <= '0;
            starve_cnt <= '0;
        end else begin
            if (state == IDLE && start)
                index <= '0;
            else if (dma_grant && !last)
                index <= index + IDX_W'(1);
            if (state == READ && !dma_grant)
                starve_cnt <= starve_cnt + SW'(1);
            else
                starve_cnt <= '0;
        end
    end

    // Message buffer: capture dmem_q on each granted read cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++)
                word[i] <= '0;
        end else if (dma_grant) begin
            word[index] <= dmem_q;
        end
    end

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_pack
        assign message_out[(NUM_WORDS-i)*DATA_W-1 -: DATA_W] = word[i];
    end

endmodule
